cache_assoc_ctrl: RTL and testbench
===================================

# cache_assoc_ctrl

Parametrised N-way set-associative, write-back, write-allocate data cache with integrated miss controller. It sits between the CPU load/store stage and the word-wide memory interface. Relative to the direct-mapped line store, it adds associativity, LRU replacement, autonomous dirty-line write-back and refill sequencing, a CPU/memory handshake, and hit/miss counters.

## Interface
- ADDR_BITS, 32, address width
- WORD_BITS, 32, data word width
- WORD_BYTES_WIDTH, 2, log2 bytes per word
- LINE_WORDS_WIDTH, 2, log2 words per line
- SET_INDEX_WIDTH, 5, log2 number of sets
- WAY_WIDTH, 1, log2 ways (0..2, i.e. 1/2/4 ways)
- TAG_BITS, derived: ADDR_BITS−SET_INDEX_WIDTH−LINE_WORDS_WIDTH−WORD_BYTES_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  request; accepted when high while cpu_busy=0
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_BITS  byte address; low WORD_BYTES_WIDTH bits ignored
- cpu_din  in  WORD_BITS  store data
- cpu_busy  out  1  high from the cycle after acceptance until the cycle after cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_dout  out  WORD_BITS  load data, valid while cpu_ack=1
- mem_cs  out  1  memory word request
- mem_we  out  1  1=write-back word, 0=refill read
- mem_addr  out  ADDR_BITS  word-aligned memory address
- mem_dout  out  WORD_BITS  write-back data
- mem_din  in  WORD_BITS  refill data, sampled when mem_ack=1
- mem_ack  in  1  word transfer complete
- hit_count, miss_count  out  32  performance counters

## Operation
- Address split, high to low: tag | set | word | byte.
- Per set and way: valid, dirty, tag, and line data. Per set: LRU state.
- FSM states:
  - IDLE: on cpu_req, latch addr/we/din, then go to LOOKUP.
  - LOOKUP: compare all ways.
    - Hit: load reads the word; store writes the word and sets dirty. Touch LRU, increment hit_count (only on the first lookup of a request), go to RESP.
    - Miss: increment miss_count and select a victim.
    - Victim selection: lowest-index invalid way, else the LRU way.
    - If the victim is valid and dirty, go to WB; else go to FILL.
  - WB: write the victim line, word 0 first. mem_we=1, mem_addr={victim tag,set,cnt,0}. Advance cnt on mem_ack. After the last word, go to FILL.
  - FILL: mem_we=0, mem_addr={req tag,set,cnt,0}. On each mem_ack, write mem_din into the victim word cnt. After the last word: valid=1, dirty=0, tag=req tag, return to LOOKUP (guaranteed hit; no hit_count increment).
  - RESP: cpu_ack=1, registered cpu_dout, then go to IDLE.
- LRU (per-way age of WAY_WIDTH bits): the touched way gets age 0. Ways younger than its old age increment. Victim is the way with age WAY_NUM−1. Reset age[w]=w.
- WAY_WIDTH=0 degenerates to direct-mapped with no LRU logic.

## Timing
- Reset values:
  - State IDLE.
  - All valid=0, dirty=0, LRU ages reset, counters 0.
  - cpu_busy/cpu_ack/mem_cs/mem_we=0; cpu_dout/mem_addr/mem_dout=0.
- Hit latency: accept at cycle 0, LOOKUP at cycle 1, cpu_ack at cycle 2.
- Miss latency (clean victim): 2 + (words × memory latency) + 2 cycles.
- mem_cs, mem_addr, and mem_dout are held stable until mem_ack. mem_cs may stay high across consecutive words. mem_ack while mem_cs=0 is ignored.
- cpu_req while busy is ignored. A request held high through RESP is accepted as a new request in the following IDLE cycle.
- cnt wraps at 2^LINE_WORDS_WIDTH−1 to 0 on the WB→FILL transition.
- Reset mid-WB/FILL: abort at the edge. A partially filled line stays invalid. Dirty data is discarded.
- Counters wrap modulo 2^32.

## Structure
- Package cache_pkg holds:
  - FSM state enum (IDLE, LOOKUP, WB, FILL, RESP).
  - Address field width/offset localparams.
  - Tag-extract and set-extract functions.
- Sub-module cache_lru holds the per-set age arrays. Its interface: set index and touch way in; touch enable in; victim way out.

## Test plan
Defaults: 2 ways, 32 sets, 4-word lines; set field is addr[8:4].
- Cold load 0x0000_0010, memory returns 0xA0..0xA3 for words 0..3 -> 4 reads at 0x10,0x14,0x18,0x1C; cpu_dout=0xA0; miss_count=1.
- Then load 0x0000_0014 -> cpu_ack at cycle 2; cpu_dout=0xA1; hit_count=1; mem_cs stays 0.
- Store 0x1234 to 0x000 (miss, fill), load 0x200 (fill into way 1), load 0x400 -> victim is the 0x000 line; WB writes 0x1234 at 0x000 first; then FILL reads 0x400.
- Access 0x000, 0x200, 0x000, then 0x400 -> 0x200 is evicted (LRU); no WB because that line is clean.
- Assert rst during the 2nd FILL word -> next cycle mem_cs=0 and cpu_busy=0; reload of the same address misses again.
- Force 2^32 hits via counter preload in the bench -> hit_count wraps to 0.

Source files
------------

// File: rtl/cache_assoc_ctrl_pkg.sv
// Shared types and address helpers for the set-associative write-back cache.
// Module parameters take their defaults from here.
package cache_pkg;

   localparam int ADDR_MAX             = 64;
   localparam int DEF_ADDR_BITS        = 32;
   localparam int DEF_WORD_BITS        = 32;
   localparam int DEF_WORD_BYTES_WIDTH = 2;
   localparam int DEF_LINE_WORDS_WIDTH = 2;
   localparam int DEF_SET_INDEX_WIDTH  = 5;
   localparam int DEF_WAY_WIDTH        = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      WB     = 3'd2,
      FILL   = 3'd3,
      RESP   = 3'd4
   } state_t;

   function automatic logic [ADDR_MAX-1:0] extract_tag(input logic [ADDR_MAX-1:0] addr,
                                                       input int tag_lsb);
      return addr >> tag_lsb;
   endfunction

   function automatic logic [ADDR_MAX-1:0] extract_set(input logic [ADDR_MAX-1:0] addr,
                                                       input int set_lsb,
                                                       input int set_width);
      return (addr >> set_lsb) & ~({ADDR_MAX{1'b1}} << set_width);
   endfunction

endpackage

// File: rtl/cache_assoc_ctrl_lru.sv
// Per-set age-based LRU tracker: touched way becomes youngest, victim is the oldest.
// With a single way it collapses to a constant victim of 0.
module cache_lru
   import cache_pkg::*;
#(
   parameter int SET_INDEX_WIDTH = DEF_SET_INDEX_WIDTH,
   parameter int WAY_WIDTH       = DEF_WAY_WIDTH,
   localparam int AW             = (WAY_WIDTH > 0) ? WAY_WIDTH : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SET_INDEX_WIDTH-1:0] set_idx,
   input  logic                       touch_en,
   input  logic [AW-1:0]              touch_way,
   output logic [AW-1:0]              victim_way
);

   generate
      if (WAY_WIDTH == 0) begin : g_direct
         assign victim_way = '0;
      end else begin : g_lru
         localparam int WAYS = 1 << WAY_WIDTH;
         localparam int SETS = 1 << SET_INDEX_WIDTH;

         logic [WAY_WIDTH-1:0] age [SETS][WAYS];

         // age update: touched way to 0, ways younger than its old age grow older
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < SETS; s++) begin
                  for (int w = 0; w < WAYS; w++) begin
                     age[s][w] <= WAY_WIDTH'(w);
                  end
               end
            end else if (touch_en) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (AW'(w) == touch_way) begin
                     age[set_idx][w] <= '0;
                  end else if (age[set_idx][w] < age[set_idx][touch_way]) begin
                     age[set_idx][w] <= age[set_idx][w] + WAY_WIDTH'(1);
                  end
               end
            end
         end

         // victim: the way holding the oldest age in the addressed set
         always_comb begin
            victim_way = '0;
            for (int w = 0; w < WAYS; w++) begin
               victim_way = (age[set_idx][w] == WAY_WIDTH'(WAYS - 1)) ? AW'(w) : victim_way;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back, write-allocate data cache with miss controller.
// Lines are refilled and written back one word at a time over a req/ack memory port.
module cache_assoc_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_BITS        = DEF_ADDR_BITS,
   parameter int WORD_BITS        = DEF_WORD_BITS,
   parameter int WORD_BYTES_WIDTH = DEF_WORD_BYTES_WIDTH,
   parameter int LINE_WORDS_WIDTH = DEF_LINE_WORDS_WIDTH,
   parameter int SET_INDEX_WIDTH  = DEF_SET_INDEX_WIDTH,
   parameter int WAY_WIDTH        = DEF_WAY_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [WORD_BITS-1:0] cpu_din,
   output logic                 cpu_busy,
   output logic                 cpu_ack,
   output logic [WORD_BITS-1:0] cpu_dout,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [WORD_BITS-1:0] mem_dout,
   input  logic [WORD_BITS-1:0] mem_din,
   input  logic                 mem_ack,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
);

   localparam int TAG_BITS = ADDR_BITS - SET_INDEX_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH;
   localparam int WAYS     = 1 << WAY_WIDTH;
   localparam int SETS     = 1 << SET_INDEX_WIDTH;
   localparam int WORDS    = 1 << LINE_WORDS_WIDTH;
   localparam int AW       = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;
   localparam int SET_LSB  = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;
   localparam int TAG_LSB  = SET_LSB + SET_INDEX_WIDTH;

   state_t                      state;
   logic [ADDR_BITS-1:0]        req_addr;
   logic                        req_we;
   logic [WORD_BITS-1:0]        req_din;
   logic [LINE_WORDS_WIDTH-1:0] cnt;
   logic [AW-1:0]               victim;
   logic                        refilled;

   logic                        valid [SETS][WAYS];
   logic                        dirty [SETS][WAYS];
   logic [TAG_BITS-1:0]         tags  [SETS][WAYS];
   logic [WORD_BITS-1:0]        data  [SETS][WAYS][WORDS];

   logic [SET_INDEX_WIDTH-1:0]  req_set;
   logic [TAG_BITS-1:0]         req_tag;
   logic [LINE_WORDS_WIDTH-1:0] req_word;
   logic [LINE_WORDS_WIDTH-1:0] nxt_cnt;
   logic                        last_word;
   logic                        hit;
   logic [AW-1:0]               hit_way;
   logic                        inv_found;
   logic [AW-1:0]               inv_way;
   logic [AW-1:0]               lru_way;
   logic [AW-1:0]               pick;
   logic                        xfer;

   assign req_set   = SET_INDEX_WIDTH'(extract_set(ADDR_MAX'(req_addr), SET_LSB, SET_INDEX_WIDTH));
   assign req_tag   = TAG_BITS'(extract_tag(ADDR_MAX'(req_addr), TAG_LSB));
   assign req_word  = req_addr[SET_LSB-1:WORD_BYTES_WIDTH];
   assign nxt_cnt   = cnt + LINE_WORDS_WIDTH'(1);
   assign last_word = (cnt == LINE_WORDS_WIDTH'(WORDS - 1));
   assign xfer      = mem_cs && mem_ack;
   assign pick      = inv_found ? inv_way : lru_way;

   // tag match across all ways and lowest-index invalid way; descending loop leaves the lowest
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit       = hit | (valid[req_set][w] && (tags[req_set][w] == req_tag));
         hit_way   = (valid[req_set][w] && (tags[req_set][w] == req_tag)) ? AW'(w) : hit_way;
         inv_found = inv_found | !valid[req_set][w];
         inv_way   = !valid[req_set][w] ? AW'(w) : inv_way;
      end
   end

   cache_lru #(
      .SET_INDEX_WIDTH(SET_INDEX_WIDTH),
      .WAY_WIDTH      (WAY_WIDTH)
   ) u_lru (
      .clk       (clk),
      .rst       (rst),
      .set_idx   (req_set),
      .touch_en  ((state == LOOKUP) && hit),
      .touch_way (hit_way),
      .victim_way(lru_way)
   );

   // line store: victim invalidated on miss so an aborted refill never looks valid
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid[s][w] <= 1'b0;
               dirty[s][w] <= 1'b0;
            end
         end
      end else begin
         if ((state == LOOKUP) && !hit) begin
            valid[req_set][pick] <= 1'b0;
         end
         if ((state == FILL) && xfer) begin
            data[req_set][victim][cnt] <= mem_din;
            if (last_word) begin
               valid[req_set][victim] <= 1'b1;
               dirty[req_set][victim] <= 1'b0;
               tags[req_set][victim]  <= req_tag;
            end
         end
         if ((state == LOOKUP) && hit && req_we) begin
            data[req_set][hit_way][req_word] <= req_din;
            dirty[req_set][hit_way]          <= 1'b1;
         end
      end
   end

   // controller FSM with registered CPU and memory outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_we     <= 1'b0;
         req_din    <= '0;
         cnt        <= '0;
         victim     <= '0;
         refilled   <= 1'b0;
         cpu_busy   <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_dout   <= '0;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_dout   <= '0;
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               cpu_ack <= 1'b0;
               if (cpu_req) begin
                  req_addr <= cpu_addr;
                  req_we   <= cpu_we;
                  req_din  <= cpu_din;
                  refilled <= 1'b0;
                  cpu_busy <= 1'b1;
                  state    <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (!refilled) begin
                     hit_count <= hit_count + 32'd1;
                  end
                  if (!req_we) begin
                     cpu_dout <= data[req_set][hit_way][req_word];
                  end
                  cpu_ack <= 1'b1;
                  state   <= RESP;
               end else begin
                  miss_count <= miss_count + 32'd1;
                  victim     <= pick;
                  cnt        <= '0;
                  mem_cs     <= 1'b1;
                  if (valid[req_set][pick] && dirty[req_set][pick]) begin
                     mem_we   <= 1'b1;
                     mem_addr <= {tags[req_set][pick], req_set, {LINE_WORDS_WIDTH{1'b0}},
                                  {WORD_BYTES_WIDTH{1'b0}}};
                     mem_dout <= data[req_set][pick][0];
                     state    <= WB;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= {req_tag, req_set, {LINE_WORDS_WIDTH{1'b0}},
                                  {WORD_BYTES_WIDTH{1'b0}}};
                     state    <= FILL;
                  end
               end
            end
            WB: begin
               if (xfer) begin
                  if (last_word) begin
                     cnt      <= '0;
                     mem_we   <= 1'b0;
                     mem_addr <= {req_tag, req_set, {LINE_WORDS_WIDTH{1'b0}},
                                  {WORD_BYTES_WIDTH{1'b0}}};
                     state    <= FILL;
                  end else begin
                     cnt      <= nxt_cnt;
                     mem_addr <= {tags[req_set][victim], req_set, nxt_cnt, {WORD_BYTES_WIDTH{1'b0}}};
                     mem_dout <= data[req_set][victim][nxt_cnt];
                  end
               end
            end
            FILL: begin
               if (xfer) begin
                  if (last_word) begin
                     cnt      <= '0;
                     mem_cs   <= 1'b0;
                     refilled <= 1'b1;
                     state    <= LOOKUP;
                  end else begin
                     cnt      <= nxt_cnt;
                     mem_addr <= {req_tag, req_set, nxt_cnt, {WORD_BYTES_WIDTH{1'b0}}};
                  end
               end
            end
            RESP: begin
               cpu_ack  <= 1'b0;
               cpu_busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed self-checking bench for cache_assoc_ctrl with a word-wide memory model.
// Each scenario task drives requests and compares against hand-computed values.
module tb_cache_assoc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic [31:0] cpu_din = 32'd0;
   logic        cpu_busy, cpu_ack, mem_cs, mem_we;
   logic [31:0] cpu_dout, mem_addr, mem_dout;
   logic [31:0] mem_din = 32'd0;
   logic        mem_ack = 1'b0;
   logic [31:0] hit_count, miss_count;

   int errors = 0;
   int checks = 0;
   int cs_cycles = 0;
   logic busy_at1;

   logic [31:0] mem [1024];
   logic [31:0] log_addr [$];
   logic        log_we   [$];
   logic [31:0] log_data [$];

   always #5 clk = ~clk;

   cache_assoc_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // memory model: acks every other cycle while mem_cs is high, logs each transfer
   always @(negedge clk) begin
      if (mem_cs) cs_cycles++;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_cs) begin
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_data.push_back(mem_we ? mem_dout : mem[mem_addr[11:2]]);
         if (mem_we) mem[mem_addr[11:2]] = mem_dout;
         else        mem_din = mem[mem_addr[11:2]];
         mem_ack = 1'b1;
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         output logic [31:0] dout, output int lat);
      bit done;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      lat = 0; done = 0; dout = 32'd0; busy_at1 = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) busy_at1 = cpu_busy;
         if (cpu_ack) begin
            done = 1;
            dout = cpu_dout;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL req_timeout: addr %h got no cpu_ack, required ack within 200 cycles", addr);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      checks++; if ({cpu_busy, cpu_ack, mem_cs, mem_we} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: got %b required 0000", {cpu_busy, cpu_ack, mem_cs, mem_we});
      end
      checks++; if ({cpu_dout, mem_addr, mem_dout} !== 96'd0) begin
         errors++; $display("FAIL reset_data: got %h %h %h required zeros", cpu_dout, mem_addr, mem_dout);
      end
      checks++; if ({hit_count, miss_count} !== 64'd0) begin
         errors++; $display("FAIL reset_counts: got %0d %0d required 0 0", hit_count, miss_count);
      end
   endtask

   task automatic test_cold_load();
      logic [31:0] d; int lat; int base;
      base = log_addr.size();
      do_req(1'b0, 32'h0000_0010, 32'd0, d, lat);
      checks++; if (log_addr.size() - base != 4) begin
         errors++; $display("FAIL cold_xfers: got %0d required 4", log_addr.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (log_addr[base+i] !== 32'h10 + 32'(4*i) || log_we[base+i] !== 1'b0) begin
               errors++; $display("FAIL cold_read%0d: got addr %h we %b required %h read", i,
                                  log_addr[base+i], log_we[base+i], 32'h10 + 32'(4*i));
            end
         end
      end
      checks++; if (d !== 32'hA0) begin
         errors++; $display("FAIL cold_dout: got %h required 000000a0", d);
      end
      checks++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
         errors++; $display("FAIL cold_counts: got miss %0d hit %0d required 1 0", miss_count, hit_count);
      end
   endtask

   task automatic test_hit();
      logic [31:0] d; int lat; int cs0;
      cs0 = cs_cycles;
      do_req(1'b0, 32'h0000_0014, 32'd0, d, lat);
      checks++; if (lat != 2) begin
         errors++; $display("FAIL hit_latency: got %0d required 2", lat);
      end
      checks++; if (busy_at1 !== 1'b1) begin
         errors++; $display("FAIL hit_busy: got %b required 1", busy_at1);
      end
      checks++; if (d !== 32'hA1) begin
         errors++; $display("FAIL hit_dout: got %h required 000000a1", d);
      end
      checks++; if (hit_count !== 32'd1) begin
         errors++; $display("FAIL hit_count: got %0d required 1", hit_count);
      end
      checks++; if (cs_cycles != cs0) begin
         errors++; $display("FAIL hit_mem_idle: got %0d mem_cs cycles required 0", cs_cycles - cs0);
      end
   endtask

   task automatic test_dirty_wb();
      logic [31:0] d; int lat; int base;
      do_req(1'b1, 32'h0000_0000, 32'h1234, d, lat);
      do_req(1'b0, 32'h0000_0200, 32'd0, d, lat);
      base = log_addr.size();
      do_req(1'b0, 32'h0000_0400, 32'd0, d, lat);
      checks++; if (log_addr.size() - base != 8) begin
         errors++; $display("FAIL wb_xfers: got %0d required 8", log_addr.size() - base);
      end else begin
         checks++; if ({log_we[base], log_addr[base], log_data[base]} !== {1'b1, 32'h0, 32'h1234}) begin
            errors++; $display("FAIL wb_first: got we %b addr %h data %h required 1 0 1234",
                               log_we[base], log_addr[base], log_data[base]);
         end
         checks++; if ({log_we[base+3], log_addr[base+3], log_data[base+3]} !==
                       {1'b1, 32'hC, 32'hC000_000C}) begin
            errors++; $display("FAIL wb_last: got we %b addr %h data %h required 1 c c000000c",
                               log_we[base+3], log_addr[base+3], log_data[base+3]);
         end
         checks++; if ({log_we[base+4], log_addr[base+4]} !== {1'b0, 32'h400}) begin
            errors++; $display("FAIL wb_then_fill: got we %b addr %h required 0 400",
                               log_we[base+4], log_addr[base+4]);
         end
      end
      checks++; if (d !== 32'hC000_0400) begin
         errors++; $display("FAIL wb_dout: got %h required c0000400", d);
      end
      checks++; if (miss_count !== 32'd4 || hit_count !== 32'd1) begin
         errors++; $display("FAIL wb_counts: got miss %0d hit %0d required 4 1", miss_count, hit_count);
      end
   endtask

   task automatic test_lru();
      logic [31:0] d; int lat; int base; int nwr;
      apply_reset();
      do_req(1'b0, 32'h0000_0000, 32'd0, d, lat);
      checks++; if (d !== 32'h1234) begin
         errors++; $display("FAIL lru_wb_data: got %h required 00001234", d);
      end
      do_req(1'b0, 32'h0000_0200, 32'd0, d, lat);
      do_req(1'b0, 32'h0000_0000, 32'd0, d, lat);
      base = log_addr.size();
      do_req(1'b0, 32'h0000_0400, 32'd0, d, lat);
      nwr = 0;
      for (int i = base; i < log_addr.size(); i++) if (log_we[i]) nwr++;
      checks++; if (nwr != 0 || log_addr.size() - base != 4) begin
         errors++; $display("FAIL lru_clean_evict: got %0d writes %0d xfers required 0 4",
                            nwr, log_addr.size() - base);
      end
      base = log_addr.size();
      do_req(1'b0, 32'h0000_0000, 32'd0, d, lat);
      checks++; if (log_addr.size() != base || hit_count !== 32'd2) begin
         errors++; $display("FAIL lru_kept: got %0d xfers hit %0d required 0 2", log_addr.size() - base, hit_count);
      end
      do_req(1'b0, 32'h0000_0200, 32'd0, d, lat);
      checks++; if (miss_count !== 32'd4 || d !== 32'hC000_0200) begin
         errors++; $display("FAIL lru_evicted: got miss %0d dout %h required 4 c0000200", miss_count, d);
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] d; int lat; int base; bit seen;
      apply_reset();
      base = log_addr.size();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0800;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (log_addr.size() >= base + 1) seen = 1;
      end
      checks++; if (!seen || mem_cs !== 1'b1 || mem_addr !== 32'h804) begin
         errors++; $display("FAIL midfill_word2: got seen %b cs %b addr %h required 1 1 804", seen, mem_cs, mem_addr);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (mem_cs !== 1'b0 || cpu_busy !== 1'b0) begin
         errors++; $display("FAIL midfill_abort: got cs %b busy %b required 0 0", mem_cs, cpu_busy);
      end
      rst = 1'b0;
      base = log_addr.size();
      do_req(1'b0, 32'h0000_0800, 32'd0, d, lat);
      checks++; if (miss_count !== 32'd1 || log_addr.size() - base != 4 || d !== 32'hC000_0800) begin
         errors++; $display("FAIL midfill_reload: got miss %0d xfers %0d dout %h required 1 4 c0000800",
                            miss_count, log_addr.size() - base, d);
      end
   endtask

   task automatic test_counter_wrap();
      logic [31:0] d; int lat;
      @(negedge clk);
      force dut.hit_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.hit_count;
      do_req(1'b0, 32'h0000_0804, 32'd0, d, lat);
      checks++; if (hit_count !== 32'd0 || d !== 32'hC000_0804) begin
         errors++; $display("FAIL hit_wrap: got hit %h dout %h required 0 c0000804", hit_count, d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i << 2);
      mem[4] = 32'hA0; mem[5] = 32'hA1; mem[6] = 32'hA2; mem[7] = 32'hA3;
      test_reset();
      test_cold_load();
      test_hit();
      test_dirty_wb();
      test_lru();
      test_reset_mid_fill();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
